// File: rtl/fixed_point_pkg.sv
// Fixed-point helpers shared by the multiply/add and dot-accumulate stages.
// Functions work on a 64-bit signed carrier; callers sign-extend into it and slice out.
package fixed_point_pkg;

    localparam int MAX_W = 64;

    function automatic int acc_width(input int in_width, input int acc_guard);
        return in_width + acc_guard;
    endfunction

    function automatic logic signed [MAX_W-1:0] round_half_away(
        input logic signed [MAX_W-1:0] value,
        input int                      shift
    );
        logic signed [MAX_W-1:0] half;
        half = 64'sd1 <<< (shift - 1);
        if (value >= 0) begin
            return (value + half) >>> shift;
        end
        // One less bias on the negative side makes exact halves round away from zero.
        return (value + half - 64'sd1) >>> shift;
    endfunction

    // Returns {sat, clamped value}.
    function automatic logic [MAX_W:0] saturate(
        input logic signed [MAX_W-1:0] value,
        input int                      out_width
    );
        logic signed [MAX_W-1:0] max_v;
        logic signed [MAX_W-1:0] min_v;
        max_v = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_width - 1));
        if (value > max_v) begin
            return {1'b1, max_v};
        end
        if (value < min_v) begin
            return {1'b1, min_v};
        end
        return {1'b0, value};
    endfunction

endpackage

// File: rtl/fixed_point_round_sat.sv
// Round-half-away-from-zero then saturate a signed accumulator sum to OUT_WIDTH.
// Purely combinational, no latency, no handshake.
module fixed_point_round_sat
    import fixed_point_pkg::*;
#(
    parameter int ACC_W      = 36,
    parameter int FRAC_SHIFT = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic [ACC_W-1:0]     sum_i,
    output logic [OUT_WIDTH-1:0] result_o,
    output logic                 sat_o
);

    logic signed [MAX_W-1:0] wide;
    logic signed [MAX_W-1:0] rounded;
    logic [MAX_W:0]          clamped;
    logic                    unused_hi;

    always_comb begin
        wide      = {{(MAX_W-ACC_W){sum_i[ACC_W-1]}}, sum_i};
        rounded   = round_half_away(wide, FRAC_SHIFT);
        clamped   = saturate(rounded, OUT_WIDTH);
        sat_o     = clamped[MAX_W];
        result_o  = clamped[OUT_WIDTH-1:0];
        unused_hi = ^clamped[MAX_W-1:OUT_WIDTH];
    end

endmodule

// File: rtl/fixed_point_dot_accumulator.sv
// Accumulates VEC_LEN signed products, rounds/saturates the sum; result 1 cycle after last accept.
// Stalls only the completing element while a previous result is still held on valid_o/ready_i.
module fixed_point_dot_accumulator
    import fixed_point_pkg::*;
#(
    parameter int IN_WIDTH   = 32,
    parameter int VEC_LEN    = 4,
    parameter int ACC_GUARD  = 4,
    parameter int FRAC_SHIFT = 8,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  prod_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic                 clear_i,
    output logic [OUT_WIDTH-1:0] result_o,
    output logic                 sat_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    localparam int ACC_W = acc_width(IN_WIDTH, ACC_GUARD);
    localparam int CNT_W = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

    if (VEC_LEN < 2) begin : g_chk_len
        $error("VEC_LEN must be at least 2");
    end
    if (ACC_GUARD < $clog2(VEC_LEN)) begin : g_chk_guard
        $error("ACC_GUARD too small to hold VEC_LEN products without overflow");
    end
    if (FRAC_SHIFT < 1) begin : g_chk_shift
        $error("FRAC_SHIFT must be at least 1");
    end
    if (OUT_WIDTH > ACC_W - FRAC_SHIFT) begin : g_chk_out
        $error("OUT_WIDTH exceeds the rounded accumulator width");
    end
    if (ACC_W + 1 > MAX_W) begin : g_chk_carrier
        $error("accumulator does not fit the 64-bit rounding carrier");
    end

    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] result_q, result_d;
    logic                 sat_q, sat_d;
    logic                 valid_q, valid_d;

    logic [ACC_W-1:0]     prod_ext;
    logic [ACC_W-1:0]     sum;
    logic                 last;
    logic                 accept;
    logic [OUT_WIDTH-1:0] rs_result;
    logic                 rs_sat;

    assign prod_ext = {{ACC_GUARD{prod_i[IN_WIDTH-1]}}, prod_i};
    assign sum      = (cnt_q == '0) ? prod_ext : acc_q + prod_ext;
    assign last     = (cnt_q == LAST);
    assign ready_o  = !clear_i && !(last && valid_q && !ready_i);
    assign accept   = valid_i && ready_o;

    // On the completing element sum is the final dot product.
    fixed_point_round_sat #(
        .ACC_W      (ACC_W),
        .FRAC_SHIFT (FRAC_SHIFT),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_round_sat (
        .sum_i    (sum),
        .result_o (rs_result),
        .sat_o    (rs_sat)
    );

    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        sat_d    = sat_q;
        valid_d  = valid_q && !ready_i;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            acc_d = sum;
            if (last) begin
                cnt_d    = '0;
                result_d = rs_result;
                sat_d    = rs_sat;
                valid_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
        end
    end

    assign result_o = result_q;
    assign sat_o    = sat_q;
    assign valid_o  = valid_q;

endmodule
